basic_cpu_sequencer: RTL and testbench

Instruction-cycle sequencer for the 16-bit basic accumulator CPU. It owns the sequence counter, timing one-hot T and registered opcode one-hot D, and issues per-cycle micro-operation strobes to the AR/PC/DR/AC/IR/memory datapath. It covers the fetch, decode, indirect and execute phases, plus start/halt control.

---
 rtl/basic_cpu_sequencer_pkg.sv | 12 +
 rtl/basic_cpu_sequencer_seq_counter.sv | 17 +
 rtl/basic_cpu_sequencer.sv | 133 +++++++++++++
 tb/tb_basic_cpu_sequencer.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/basic_cpu_sequencer_pkg.sv
// basic_cpu_pkg: micro-op strobe bit indices and opcode constants for the basic accumulator CPU.
package basic_cpu_pkg;
   localparam int UOP_W = 22;
   localparam int AR_LD_PC  = 0,  AR_LD_IR  = 1,  AR_LD_MEM = 2,  AR_INR    = 3,
                  AR_CLR    = 4,  IR_LD     = 5,  PC_INR    = 6,  PC_LD_AR  = 7,
                  PC_CLR    = 8,  MEM_RD    = 9,  MEM_WR_AC = 10, MEM_WR_PC = 11,
                  MEM_WR_DR = 12, MEM_WR_TR = 13, TR_LD_PC  = 14, DR_LD     = 15,
                  DR_INR    = 16, AC_AND    = 17, AC_ADD    = 18, AC_LD_DR  = 19,
                  REG_EXEC  = 20, IO_EXEC   = 21;
   localparam int OP_AND = 0, OP_ADD = 1, OP_LDA = 2, OP_STA = 3,
                  OP_BUN = 4, OP_BSA = 5, OP_ISZ = 6, OP_REG = 7;
endpackage

// File: rtl/basic_cpu_sequencer_seq_counter.sv
// seq_counter: sequence counter, clear has priority over increment, wraps naturally at its maximum.
module seq_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);
   logic [W-1:0] cnt_d, cnt_q;
   assign cnt_d = clr ? '0 : inc ? cnt_q + W'(1) : cnt_q;
   assign cnt = cnt_q;
   always_ff @(posedge clk or posedge rst)
      if (rst) cnt_q <= '0;
      else cnt_q <= cnt_d;
endmodule

// File: rtl/basic_cpu_sequencer.sv
// basic_cpu_sequencer: fetch/decode/indirect/execute micro-op sequencer; define INTERRUPT_EN for the interrupt cycle.
module basic_cpu_sequencer
   import basic_cpu_pkg::*;
#(
   parameter int SC_W       = 4,
   parameter bit AUTO_START = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [15:0]          ir,
   input  logic                 dr_zero,
   output logic [2**SC_W-1:0]   t,
   output logic [7:0]           d,
   output logic                 i_ind,
   output logic                 running,
   output logic [UOP_W-1:0]     uop,
   output logic                 instr_done
`ifdef INTERRUPT_EN
   ,
   input  logic                 irq,
   output logic                 ien,
   output logic                 r_cycle
`endif
);
   localparam int TW = 2**SC_W;
   logic [SC_W-1:0] sc;
   logic [3:0] step;
   logic [7:0] d_q, d_d;
   logic s_q, s_d, i_q, i_d, run, irc, hlt, clr, unused_ir;
   assign step = 4'(sc);
   assign run = s_q && !rst;
   assign clr = instr_done || !s_q;
   assign t = run ? TW'(1) << sc : '0;
   assign d = d_q;
   assign i_ind = i_q;
   assign running = s_q;
   assign unused_ir = ^{ir[11:1]};
   seq_counter #(.W(SC_W)) u_sc (.clk(clk), .rst(rst), .clr(clr), .inc(s_q), .cnt(sc));
`ifdef INTERRUPT_EN
   logic ien_q, ien_d, r_q, r_d;
   // R may rise mid-instruction; it only redirects sequencing once the counter is back at T0..T2
   assign irc = r_q && step < 4'd3;
   assign ien = ien_q;
   assign r_cycle = r_q;
   always_comb begin
      ien_d = (irc && instr_done) ? 1'b0 : uop[IO_EXEC] ? (ir[7] || ien_q) && !ir[6] : ien_q;
      r_d = (irc && instr_done) ? 1'b0 : r_q || (run && step > 4'd2 && ien_q && irq);
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         ien_q <= 1'b0;
         r_q <= 1'b0;
      end else begin
         ien_q <= ien_d;
         r_q <= r_d;
      end
`else
   assign irc = 1'b0;
`endif
   always_comb begin
      uop = '0;
      instr_done = 1'b0;
      if (run && irc) begin
`ifdef INTERRUPT_EN
         uop[AR_CLR] = step == 4'd0;
         uop[TR_LD_PC] = step == 4'd0;
         uop[MEM_WR_TR] = step == 4'd1;
         uop[PC_CLR] = step == 4'd1;
         uop[PC_INR] = step == 4'd2;
         instr_done = step == 4'd2;
`endif
      end else if (run) begin
         case (step)
            4'd0: uop[AR_LD_PC] = 1'b1;
            4'd1: begin
               uop[MEM_RD] = 1'b1;
               uop[IR_LD] = 1'b1;
               uop[PC_INR] = 1'b1;
            end
            4'd2: uop[AR_LD_IR] = 1'b1;
            4'd3:
               if (d_q[OP_REG]) begin
                  uop[i_q ? IO_EXEC : REG_EXEC] = 1'b1;
                  instr_done = 1'b1;
               end else begin
                  uop[MEM_RD] = i_q;
                  uop[AR_LD_MEM] = i_q;
               end
            4'd4: begin
               uop[MEM_RD] = d_q[OP_AND] | d_q[OP_ADD] | d_q[OP_LDA] | d_q[OP_ISZ];
               uop[DR_LD] = d_q[OP_AND] | d_q[OP_ADD] | d_q[OP_LDA] | d_q[OP_ISZ];
               uop[MEM_WR_AC] = d_q[OP_STA];
               uop[PC_LD_AR] = d_q[OP_BUN];
               uop[MEM_WR_PC] = d_q[OP_BSA];
               uop[AR_INR] = d_q[OP_BSA];
               instr_done = d_q[OP_STA] | d_q[OP_BUN];
            end
            4'd5: begin
               uop[AC_AND] = d_q[OP_AND];
               uop[AC_ADD] = d_q[OP_ADD];
               uop[AC_LD_DR] = d_q[OP_LDA];
               uop[PC_LD_AR] = d_q[OP_BSA];
               uop[DR_INR] = d_q[OP_ISZ];
               instr_done = d_q[OP_AND] | d_q[OP_ADD] | d_q[OP_LDA] | d_q[OP_BSA];
            end
            4'd6: begin
               uop[MEM_WR_DR] = d_q[OP_ISZ];
               uop[PC_INR] = d_q[OP_ISZ] & dr_zero;
               instr_done = d_q[OP_ISZ];
            end
            default: ;
         endcase
      end
   end
   always_comb begin
      // HLT beats a simultaneous start: start is only looked at while halted
      hlt = instr_done && step == 4'd3 && !irc && !i_q && ir[0];
      s_d = s_q ? !hlt : start;
      d_d = (run && !irc && step == 4'd2) ? 8'd1 << ir[14:12] : d_q;
      i_d = (run && !irc && step == 4'd2) ? ir[15] : i_q;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         s_q <= AUTO_START;
         d_q <= '0;
         i_q <= 1'b0;
      end else begin
         s_q <= s_d;
         d_q <= d_d;
         i_q <= i_d;
      end
endmodule

// File: tb/tb_basic_cpu_sequencer.sv
// tb_basic_cpu_sequencer: directed + random instructions checked against a per-opcode strobe-table model.
module tb_basic_cpu_sequencer;
   import basic_cpu_pkg::*;
   logic clk = 1'b0, rst = 1'b1, start = 1'b0, dr_zero = 1'b0;
   logic [15:0] ir = '0;
   logic [15:0] t;
   logic [7:0] d;
   logic i_ind, running, instr_done;
   logic [UOP_W-1:0] uop;
   int n_chk = 0, n_err = 0;
   logic [UOP_W-1:0] exp_q[$];
`ifdef INTERRUPT_EN
   logic irq = 1'b0, ien, r_cycle;
`endif
   always #5 clk = ~clk;

   basic_cpu_sequencer dut (
      .clk(clk), .rst(rst), .start(start), .ir(ir), .dr_zero(dr_zero), .t(t), .d(d),
      .i_ind(i_ind), .running(running), .uop(uop), .instr_done(instr_done)
`ifdef INTERRUPT_EN
      , .irq(irq), .ien(ien), .r_cycle(r_cycle)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [UOP_W-1:0] b(input int i);
      return UOP_W'(1) << i;
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // expected strobes per T-state for one instruction, straight from the opcode table
   task automatic build(input logic [15:0] x, input logic dz);
      int op = int'(x[14:12]);
      exp_q.delete();
      exp_q.push_back(b(AR_LD_PC));
      exp_q.push_back(b(MEM_RD) | b(IR_LD) | b(PC_INR));
      exp_q.push_back(b(AR_LD_IR));
      if (op == 7) exp_q.push_back(b(x[15] ? IO_EXEC : REG_EXEC));
      else begin
         exp_q.push_back(x[15] ? b(MEM_RD) | b(AR_LD_MEM) : '0);
         if (op <= 2) begin
            exp_q.push_back(b(MEM_RD) | b(DR_LD));
            exp_q.push_back(b(op == 0 ? AC_AND : op == 1 ? AC_ADD : AC_LD_DR));
         end else if (op == 3) exp_q.push_back(b(MEM_WR_AC));
         else if (op == 4) exp_q.push_back(b(PC_LD_AR));
         else if (op == 5) begin
            exp_q.push_back(b(MEM_WR_PC) | b(AR_INR));
            exp_q.push_back(b(PC_LD_AR));
         end else begin
            exp_q.push_back(b(MEM_RD) | b(DR_LD));
            exp_q.push_back(b(DR_INR));
            exp_q.push_back(b(MEM_WR_DR) | (dz ? b(PC_INR) : '0));
         end
      end
   endtask

   task automatic run_instr(input logic [15:0] x, input logic dz);
      int n;
      build(x, dz);
      n = exp_q.size();
      ir = x;
      dr_zero = dz;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         chk($sformatf("uop %h T%0d", x, k), 32'(uop), 32'(exp_q[k]));
         chk($sformatf("t %h T%0d", x, k), 32'(t), 32'(1) << k);
         chk($sformatf("done %h T%0d", x, k), 32'(instr_done), 32'(k == n - 1));
         cyc();
      end
      chk($sformatf("d %h", x), 32'(d), 32'(1) << x[14:12]);
      chk($sformatf("i_ind %h", x), 32'(i_ind), 32'(x[15]));
      chk($sformatf("running %h", x), 32'(running), 32'(!(x[14:12] == 3'd7 && !x[15] && x[0])));
   endtask

   task automatic kick();
      start = 1'b1;
      @(negedge clk);
      chk("t before start edge", 32'(t), 0);
      cyc();
      start = 1'b0;
   endtask

   initial begin
      cyc();
      @(negedge clk);
      chk("uop in reset", 32'(uop), 0);
      chk("t in reset", 32'(t), 0);
      cyc();
      rst = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk("idle t", 32'(t), 0);
         chk("idle uop", 32'(uop), 0);
         chk("idle running", 32'(running), 0);
         chk("idle done", 32'(instr_done), 0);
         cyc();
      end
      chk("reset d", 32'(d), 0);
      chk("reset i_ind", 32'(i_ind), 0);
      kick();
      run_instr(16'h1234, 1'b0);
      run_instr(16'h9234, 1'b0);
      run_instr(16'h6010, 1'b1);
      run_instr(16'h6010, 1'b0);
      for (int j = 0; j < 40; j++) begin
         logic [15:0] x = 16'($urandom);
         if (x[14:12] == 3'd7 && !x[15]) x[0] = 1'b0;
         run_instr(x, 1'($urandom));
      end
      start = 1'b1;
      run_instr(16'h7001, 1'b0);
      start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("halted t", 32'(t), 0);
         chk("halted uop", 32'(uop), 0);
         chk("halted running", 32'(running), 0);
         cyc();
      end
      kick();
      build(16'h5123, 1'b0);
      ir = 16'h5123;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk($sformatf("bsa uop T%0d", k), 32'(uop), 32'(exp_q[k]));
         cyc();
      end
      chk("bsa uop T4", 32'(uop), 32'(b(MEM_WR_PC) | b(AR_INR)));
      rst = 1'b1;
      #1;
      chk("rst uop", 32'(uop), 0);
      chk("rst t", 32'(t), 0);
      chk("rst done", 32'(instr_done), 0);
      cyc();
      rst = 1'b0;
      @(negedge clk);
      chk("post rst running", 32'(running), 0);
      chk("post rst t", 32'(t), 0);
      chk("post rst d", 32'(d), 0);
      chk("post rst uop", 32'(uop), 0);
      cyc();
      kick();
      run_instr(16'h2abc, 1'b0);
`ifdef INTERRUPT_EN
      run_instr(16'hF080, 1'b0);
      chk("ien after ION", 32'(ien), 1);
      irq = 1'b1;
      run_instr(16'h1234, 1'b0);
      chk("r set", 32'(r_cycle), 1);
      begin
         logic [UOP_W-1:0] rt[3];
         rt[0] = b(AR_CLR) | b(TR_LD_PC);
         rt[1] = b(MEM_WR_TR) | b(PC_CLR);
         rt[2] = b(PC_INR);
         for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("irq uop RT%0d", k), 32'(uop), 32'(rt[k]));
            chk($sformatf("irq done RT%0d", k), 32'(instr_done), 32'(k == 2));
            cyc();
         end
      end
      chk("ien after RT2", 32'(ien), 0);
      chk("r after RT2", 32'(r_cycle), 0);
      irq = 1'b0;
      run_instr(16'h0111, 1'b0);
`endif
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
